// File: rtl/instr_cycle_controller.sv
// Instruction cycle controller for a basic accumulator machine.
// Decodes the external T-state and latched instruction fields into the
// register, bus, ALU and memory strobes for fetch, indirect and execute.
`timescale 1ns/1ps
module instr_cycle_controller (
   input  logic        CLK,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  t_count,
   input  logic [15:0] ir,
   input  logic        dr_zero,
   input  logic        mem_ack,
   output logic        sc_clr,
   output logic        sc_inc,
   output logic [2:0]  bus_sel,
   output logic        ar_ld,
   output logic        ar_inc,
   output logic        pc_ld,
   output logic        pc_inc,
   output logic        ir_ld,
   output logic        dr_ld,
   output logic        dr_inc,
   output logic        ac_ld,
   output logic [1:0]  alu_op,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic        halted
);

   typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

   localparam logic [2:0] BusAr  = 3'd1;
   localparam logic [2:0] BusPc  = 3'd2;
   localparam logic [2:0] BusDr  = 3'd3;
   localparam logic [2:0] BusAc  = 3'd4;
   localparam logic [2:0] BusIr  = 3'd5;
   localparam logic [2:0] BusMem = 3'd7;

   localparam logic [1:0] AluPass = 2'b00;
   localparam logic [1:0] AluAnd  = 2'b01;
   localparam logic [1:0] AluAdd  = 2'b10;

   state_e     state_q, state_d;
   logic       i_q;
   logic [2:0] op_q;
   logic       latch_en;

   // Only I, op and bit 0 of the instruction are decoded here.
   logic unused_ir;
   assign unused_ir = ^ir[11:1];

   assign latch_en = (state_q == StRun) && (t_count == 4'd2);

   // State register, asynchronously cleared to IDLE.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Capture addressing mode and opcode when IR is decoded at T2.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         i_q  <= 1'b0;
         op_q <= 3'd0;
      end else if (latch_en) begin
         i_q  <= ir[15];
         op_q <= ir[14:12];
      end
   end

   // Next-state and all control strobes; memory T-states stall until mem_ack.
   always_comb begin
      state_d = state_q;
      sc_clr  = 1'b0;
      sc_inc  = 1'b0;
      bus_sel = 3'd0;
      ar_ld   = 1'b0;
      ar_inc  = 1'b0;
      pc_ld   = 1'b0;
      pc_inc  = 1'b0;
      ir_ld   = 1'b0;
      dr_ld   = 1'b0;
      dr_inc  = 1'b0;
      ac_ld   = 1'b0;
      alu_op  = AluPass;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      halted  = 1'b0;

      if (!reset) begin
         unique case (state_q)
            StIdle, StHalt: begin
               halted = (state_q == StHalt);
               if (start) begin
                  sc_clr  = 1'b1;
                  state_d = StRun;
               end
            end
            StRun: begin
               case (t_count)
                  4'd0: begin
                     bus_sel = BusPc;
                     ar_ld   = 1'b1;
                     sc_inc  = 1'b1;
                  end
                  4'd1: begin
                     bus_sel = BusMem;
                     mem_rd  = 1'b1;
                     if (mem_ack) begin
                        ir_ld  = 1'b1;
                        pc_inc = 1'b1;
                        sc_inc = 1'b1;
                     end
                  end
                  4'd2: begin
                     bus_sel = BusIr;
                     ar_ld   = 1'b1;
                     sc_inc  = 1'b1;
                  end
                  4'd3: begin
                     if (op_q != 3'd7) begin
                        if (i_q) begin
                           bus_sel = BusMem;
                           mem_rd  = 1'b1;
                           if (mem_ack) begin
                              ar_ld  = 1'b1;
                              sc_inc = 1'b1;
                           end
                        end else begin
                           sc_inc = 1'b1;
                        end
                     end else begin
                        // HLT is direct op 7 with bit 0 set; anything else is a NOP.
                        sc_clr = 1'b1;
                        if (!i_q && ir[0]) begin
                           state_d = StHalt;
                        end
                     end
                  end
                  4'd4: begin
                     case (op_q)
                        3'd0, 3'd1, 3'd2, 3'd6: begin
                           bus_sel = BusMem;
                           mem_rd  = 1'b1;
                           if (mem_ack) begin
                              dr_ld  = 1'b1;
                              sc_inc = 1'b1;
                           end
                        end
                        3'd3: begin
                           bus_sel = BusAc;
                           mem_wr  = 1'b1;
                           if (mem_ack) begin
                              sc_clr = 1'b1;
                           end
                        end
                        3'd4: begin
                           bus_sel = BusAr;
                           pc_ld   = 1'b1;
                           sc_clr  = 1'b1;
                        end
                        3'd5: begin
                           bus_sel = BusPc;
                           mem_wr  = 1'b1;
                           if (mem_ack) begin
                              ar_inc = 1'b1;
                              sc_inc = 1'b1;
                           end
                        end
                        default: sc_clr = 1'b1;
                     endcase
                  end
                  4'd5: begin
                     case (op_q)
                        3'd0: begin
                           ac_ld  = 1'b1;
                           alu_op = AluAnd;
                           sc_clr = 1'b1;
                        end
                        3'd1: begin
                           ac_ld  = 1'b1;
                           alu_op = AluAdd;
                           sc_clr = 1'b1;
                        end
                        3'd2: begin
                           ac_ld  = 1'b1;
                           alu_op = AluPass;
                           sc_clr = 1'b1;
                        end
                        3'd5: begin
                           bus_sel = BusAr;
                           pc_ld   = 1'b1;
                           sc_clr  = 1'b1;
                        end
                        3'd6: begin
                           dr_inc = 1'b1;
                           sc_inc = 1'b1;
                        end
                        default: sc_clr = 1'b1;
                     endcase
                  end
                  4'd6: begin
                     if (op_q == 3'd6) begin
                        bus_sel = BusDr;
                        mem_wr  = 1'b1;
                        if (mem_ack) begin
                           sc_clr = 1'b1;
                           pc_inc = dr_zero;
                        end
                     end else begin
                        sc_clr = 1'b1;
                     end
                  end
                  // Out-of-range T-state: restart the cycle without side effects.
                  default: sc_clr = 1'b1;
               endcase
            end
            default: state_d = StIdle;
         endcase
      end
   end

endmodule
